am9511_stack_ctrl: RTL and testbench

- Am9511-style host front end for the Am9513 compatibility-tier scalar datapath.
- Accepts byte-wide data pushes and command bytes from a legacy 8-bit host port, and keeps a binary32 operand stack.
- Sequences one operation at a time onto the external combinational exec unit over a fixed busy window, then writes the result back to the stack.
- Byte-wide pop reads, status byte and sticky error flags complete the legacy programming model.

---
 rtl/am9511_stack_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_am9511_stack_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am9511_stack_ctrl.sv
// Am9511-style legacy host front end for the Am9513 scalar datapath.
// Keeps a binary32 operand stack fed byte-wise from an 8-bit host port,
// sequences one arithmetic operation at a time onto the external exec unit
// over a fixed busy window and writes the result back onto the stack.
module am9511_stack_ctrl #(
    parameter int STACK_DEPTH  = 8,
    parameter int EXEC_LATENCY = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_host_valid,
    output logic        o_host_ready,
    input  logic        i_host_is_cmd,
    input  logic [7:0]  i_host_wdata,
    input  logic        i_rd_req,
    output logic [7:0]  o_rd_data,
    output logic [7:0]  o_status,
    output logic [7:0]  o_ex_func,
    output logic [7:0]  o_ex_fmt,
    output logic [63:0] o_ex_op0,
    output logic [63:0] o_ex_op1,
    output logic [63:0] o_ex_op2,
    output logic [1:0]  o_ex_rm,
    input  logic [63:0] i_ex_value,
    input  logic [15:0] i_ex_status
);

    localparam int IW = $clog2(STACK_DEPTH);
    localparam int CW = IW + 1;
    localparam int EW = (EXEC_LATENCY > 1) ? $clog2(EXEC_LATENCY) : 1;
    localparam logic [EW-1:0] EXEC_LAST = EW'(EXEC_LATENCY - 1);
    localparam logic [CW-1:0] STACK_FULL = CW'(STACK_DEPTH);

    // Encodings shared with am9513_pkg (function codes, format, status OK).
    localparam logic [7:0]  FUNC_ADD     = 8'h01;
    localparam logic [7:0]  FUNC_SUB     = 8'h02;
    localparam logic [7:0]  FUNC_MUL     = 8'h03;
    localparam logic [7:0]  FUNC_DIV     = 8'h04;
    localparam logic [7:0]  FUNC_SQRT    = 8'h05;
    localparam logic [7:0]  FUNC_SIN     = 8'h06;
    localparam logic [7:0]  FUNC_FMA     = 8'h07;
    localparam logic [7:0]  FMT_BINARY32 = 8'h01;
    localparam logic [15:0] CAI_OK       = 16'h0000;

    typedef enum logic [0:0] {S_IDLE, S_EXEC} state_t;

    state_t         r_state;
    logic [31:0]    r_stack [STACK_DEPTH];
    logic [CW-1:0]  r_count;
    logic [1:0]     r_wr_cnt;
    logic [1:0]     r_rd_cnt;
    logic [23:0]    r_asm;
    logic [7:0]     r_rd_data;
    logic           r_err_unf;
    logic           r_err_ovf;
    logic           r_err_inv;
    logic [EW-1:0]  r_exec_cnt;
    logic [1:0]     r_nops;
    logic [7:0]     r_ex_func;
    logic [7:0]     r_ex_fmt;
    logic [63:0]    r_ex_op0;
    logic [63:0]    r_ex_op1;
    logic [63:0]    r_ex_op2;

    logic [IW-1:0]  w_idx1;
    logic [IW-1:0]  w_idx2;
    logic [IW-1:0]  w_idx3;
    logic [IW-1:0]  w_push_idx;
    logic [IW-1:0]  w_wb_idx;
    logic [31:0]    w_tos;
    logic [31:0]    w_nos;
    logic [31:0]    w_third;
    logic           w_sign;
    logic           w_zero;
    logic [7:0]     w_rd_byte;
    logic [1:0]     w_need;
    logic [7:0]     w_func;
    logic           w_known;
    logic           w_arith;
    logic           w_unused_hi;

    assign w_idx1     = IW'(r_count - CW'(1));
    assign w_idx2     = IW'(r_count - CW'(2));
    assign w_idx3     = IW'(r_count - CW'(3));
    assign w_push_idx = IW'(r_count);
    assign w_wb_idx   = IW'(r_count - CW'(r_nops));
    assign w_tos      = r_stack[w_idx1];
    assign w_nos      = r_stack[w_idx2];
    assign w_third    = r_stack[w_idx3];
    assign w_sign     = (r_count != '0) && w_tos[31];
    assign w_zero     = (r_count != '0) && (w_tos[30:0] == 31'd0);
    assign w_unused_hi = ^i_ex_value[63:32];

    assign o_host_ready = (r_state == S_IDLE);
    assign o_rd_data    = r_rd_data;
    assign o_status     = {(r_state == S_EXEC), w_sign, w_zero,
                           r_err_unf, r_err_ovf, r_err_inv, 2'b00};
    assign o_ex_func    = r_ex_func;
    assign o_ex_fmt     = r_ex_fmt;
    assign o_ex_op0     = r_ex_op0;
    assign o_ex_op1     = r_ex_op1;
    assign o_ex_op2     = r_ex_op2;
    assign o_ex_rm      = 2'b00;

    // Pick the TOS byte for a pop read, most significant byte first.
    always_comb begin
        w_rd_byte = 8'h00;
        case (r_rd_cnt)
            2'd0:    w_rd_byte = w_tos[31:24];
            2'd1:    w_rd_byte = w_tos[23:16];
            2'd2:    w_rd_byte = w_tos[15:8];
            default: w_rd_byte = w_tos[7:0];
        endcase
    end

    // Decode the command nibble into operand count and exec function.
    always_comb begin
        w_need  = 2'd0;
        w_func  = 8'h00;
        w_known = 1'b1;
        w_arith = 1'b0;
        case (i_host_wdata[3:0])
            4'h0: w_need = 2'd0;
            4'h1: begin w_need = 2'd2; w_func = FUNC_ADD;  w_arith = 1'b1; end
            4'h2: begin w_need = 2'd2; w_func = FUNC_SUB;  w_arith = 1'b1; end
            4'h3: begin w_need = 2'd2; w_func = FUNC_MUL;  w_arith = 1'b1; end
            4'h4: begin w_need = 2'd2; w_func = FUNC_DIV;  w_arith = 1'b1; end
            4'h5: begin w_need = 2'd1; w_func = FUNC_SQRT; w_arith = 1'b1; end
            4'h6: begin w_need = 2'd1; w_func = FUNC_SIN;  w_arith = 1'b1; end
            4'h7: begin w_need = 2'd3; w_func = FUNC_FMA;  w_arith = 1'b1; end
            4'h8: w_need = 2'd1;
            4'h9: w_need = 2'd2;
            default: w_known = 1'b0;
        endcase
    end

    // Main controller: host writes, pop reads, command dispatch and exec window.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_wr_cnt   <= 2'd0;
            r_rd_cnt   <= 2'd0;
            r_asm      <= 24'd0;
            r_rd_data  <= 8'h00;
            r_err_unf  <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_inv  <= 1'b0;
            r_exec_cnt <= '0;
            r_nops     <= 2'd0;
            r_ex_func  <= 8'h00;
            r_ex_fmt   <= 8'h00;
            r_ex_op0   <= 64'd0;
            r_ex_op1   <= 64'd0;
            r_ex_op2   <= 64'd0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= 32'd0;
        end else begin
            r_rd_data <= 8'h00;
            case (r_state)
                S_IDLE: begin
                    if (i_host_valid && !i_host_is_cmd) begin
                        case (r_wr_cnt)
                            2'd0: r_asm[7:0]   <= i_host_wdata;
                            2'd1: r_asm[15:8]  <= i_host_wdata;
                            2'd2: r_asm[23:16] <= i_host_wdata;
                            default: begin
                                if (r_count == STACK_FULL) begin
                                    r_err_ovf <= 1'b1;
                                end else begin
                                    r_stack[w_push_idx] <= {i_host_wdata, r_asm};
                                    r_count <= r_count + CW'(1);
                                end
                            end
                        endcase
                        r_wr_cnt <= r_wr_cnt + 2'd1;
                    end else if (i_host_valid) begin
                        r_wr_cnt <= 2'd0;
                        r_rd_cnt <= 2'd0;
                        r_asm    <= 24'd0;
                        if (!w_known) begin
                            r_err_inv <= 1'b1;
                        end else if (r_count < CW'(w_need)) begin
                            r_err_unf <= 1'b1;
                        end else if (w_arith) begin
                            r_state    <= S_EXEC;
                            r_exec_cnt <= '0;
                            r_nops     <= w_need;
                            r_ex_func  <= w_func;
                            r_ex_fmt   <= FMT_BINARY32;
                            case (w_need)
                                2'd1: begin
                                    r_ex_op0 <= {32'd0, w_tos};
                                    r_ex_op1 <= 64'd0;
                                    r_ex_op2 <= 64'd0;
                                end
                                2'd2: begin
                                    r_ex_op0 <= {32'd0, w_nos};
                                    r_ex_op1 <= {32'd0, w_tos};
                                    r_ex_op2 <= 64'd0;
                                end
                                default: begin
                                    r_ex_op0 <= {32'd0, w_third};
                                    r_ex_op1 <= {32'd0, w_nos};
                                    r_ex_op2 <= {32'd0, w_tos};
                                end
                            endcase
                        end else begin
                            case (i_host_wdata[3:0])
                                4'h0: begin
                                    r_err_unf <= 1'b0;
                                    r_err_ovf <= 1'b0;
                                    r_err_inv <= 1'b0;
                                end
                                4'h8: r_count <= r_count - CW'(1);
                                default: begin
                                    r_stack[w_idx1] <= w_nos;
                                    r_stack[w_idx2] <= w_tos;
                                end
                            endcase
                        end
                    end else if (i_rd_req) begin
                        if (r_count == '0) begin
                            r_err_unf <= 1'b1;
                        end else begin
                            r_rd_data <= w_rd_byte;
                            r_rd_cnt  <= r_rd_cnt + 2'd1;
                            if (r_rd_cnt == 2'd3) r_count <= r_count - CW'(1);
                        end
                    end
                end
                default: begin
                    if (r_exec_cnt == EXEC_LAST) begin
                        r_state   <= S_IDLE;
                        r_ex_func <= 8'h00;
                        r_ex_fmt  <= 8'h00;
                        r_ex_op0  <= 64'd0;
                        r_ex_op1  <= 64'd0;
                        r_ex_op2  <= 64'd0;
                        if (i_ex_status == CAI_OK) begin
                            r_stack[w_wb_idx] <= i_ex_value[31:0];
                            r_count <= r_count - CW'(r_nops) + CW'(1);
                        end else begin
                            r_err_inv <= 1'b1;
                        end
                    end else begin
                        r_exec_cnt <= r_exec_cnt + EW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_am9511_stack_ctrl.sv
// Self-checking bench for am9511_stack_ctrl: a table of single-cycle vectors
// followed by hand-written sequences for the multi-cycle corner cases.
module tb_am9511_stack_ctrl;

    localparam int DEPTH   = 8;
    localparam int LATENCY = 4;

    localparam logic [7:0] FUNC_ADD = 8'h01;
    localparam logic [7:0] FUNC_FMA = 8'h07;
    localparam logic [7:0] FMT_B32  = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic        hostValid;
    logic        hostReady;
    logic        hostIsCmd;
    logic [7:0]  hostWdata;
    logic        rdReq;
    logic [7:0]  rdData;
    logic [7:0]  status;
    logic [7:0]  exFunc;
    logic [7:0]  exFmt;
    logic [63:0] exOp0;
    logic [63:0] exOp1;
    logic [63:0] exOp2;
    logic [1:0]  exRm;
    logic [63:0] exValue;
    logic [15:0] exStatus;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       valid;
        logic       isCmd;
        logic [7:0] wdata;
        logic       rdReq;
        logic       expReady;
        logic [7:0] expRd;
        logic [7:0] expStatus;
    } vec_t;

    vec_t vecs[$];

    am9511_stack_ctrl #(.STACK_DEPTH(DEPTH), .EXEC_LATENCY(LATENCY)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_host_valid (hostValid),
        .o_host_ready (hostReady),
        .i_host_is_cmd(hostIsCmd),
        .i_host_wdata (hostWdata),
        .i_rd_req     (rdReq),
        .o_rd_data    (rdData),
        .o_status     (status),
        .o_ex_func    (exFunc),
        .o_ex_fmt     (exFmt),
        .o_ex_op0     (exOp0),
        .o_ex_op1     (exOp1),
        .o_ex_op2     (exOp2),
        .o_ex_rm      (exRm),
        .i_ex_value   (exValue),
        .i_ex_status  (exStatus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic v, input logic c, input logic [7:0] d,
                                   input logic r, input logic er, input logic [7:0] ed,
                                   input logic [7:0] es);
        vec_t t;
        t = {v, c, d, r, er, ed, es};
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, step past the edge and leave inputs idle.
    task automatic applyStimulus(input logic v, input logic c, input logic [7:0] d, input logic r);
        hostValid = v;
        hostIsCmd = c;
        hostWdata = d;
        rdReq     = r;
        @(posedge clk);
        #1;
        hostValid = 1'b0;
        hostIsCmd = 1'b0;
        hostWdata = 8'h00;
        rdReq     = 1'b0;
    endtask

    task automatic pushWord(input logic [31:0] w);
        applyStimulus(1'b1, 1'b0, w[7:0], 1'b0);
        applyStimulus(1'b1, 1'b0, w[15:8], 1'b0);
        applyStimulus(1'b1, 1'b0, w[23:16], 1'b0);
        applyStimulus(1'b1, 1'b0, w[31:24], 1'b0);
    endtask

    task automatic sendCmd(input logic [7:0] c);
        applyStimulus(1'b1, 1'b1, c, 1'b0);
    endtask

    task automatic readWord(input string name, input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        for (int b = 3; b >= 0; b--) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("%s byte%0d", name, 3 - b), {56'd0, rdData}, {56'd0, tmp[8*b +: 8]});
        end
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        hostValid = 1'b0;
        hostIsCmd = 1'b0;
        hostWdata = 8'h00;
        rdReq     = 1'b0;
        exValue   = 64'h0000_0000_4040_0000;
        exStatus  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ready", {63'd0, hostReady}, 64'd1);
        checkOutput("reset status", {56'd0, status}, 64'd0);
        checkOutput("reset rd_data", {56'd0, rdData}, 64'd0);
        checkOutput("reset ex_func", {56'd0, exFunc}, 64'd0);
        checkOutput("reset ex_op0", exOp0, 64'd0);
        checkOutput("reset ex_rm", {62'd0, exRm}, 64'd0);
        rst = 1'b0;

        // ADD 1.0 + 2.0 with a 4-cycle busy window, read back 3.0, then flag cases.
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 0, 8'h80, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 0, 8'h3F, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 0, 8'h40, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 1, 8'h01, 0, 0, 8'h00, 8'h80));
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 8'h80));
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 0, 8'h00, 8'h80));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 0, 8'h00, 8'h80));
        vecs.push_back(mkVec(0, 0, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 8'h40, 8'h00));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 8'h40, 8'h00));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 8'h00, 8'h10));
        vecs.push_back(mkVec(1, 1, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 1, 8'h01, 0, 1, 8'h00, 8'h10));
        vecs.push_back(mkVec(1, 1, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 1, 8'h0F, 0, 1, 8'h00, 8'h04));
        vecs.push_back(mkVec(1, 1, 8'h00, 0, 1, 8'h00, 8'h00));
        // Push -0.0: sign and zero both set.
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 0, 8'h00, 0, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 0, 8'h80, 0, 1, 8'h00, 8'h60));
        vecs.push_back(mkVec(1, 0, 8'h11, 1, 1, 8'h00, 8'h60));
        vecs.push_back(mkVec(1, 1, 8'h09, 0, 1, 8'h00, 8'h70));
        vecs.push_back(mkVec(1, 1, 8'h00, 0, 1, 8'h00, 8'h60));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 8'h80, 8'h60));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 8'h00, 8'h60));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 8'h00, 8'h60));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 0, 8'h00, 1, 1, 8'h00, 8'h10));
        vecs.push_back(mkVec(1, 1, 8'h00, 0, 1, 8'h00, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].isCmd, vecs[i].wdata, vecs[i].rdReq);
            checkOutput($sformatf("vec%0d ready", i), {63'd0, hostReady}, {63'd0, vecs[i].expReady});
            checkOutput($sformatf("vec%0d rd_data", i), {56'd0, rdData}, {56'd0, vecs[i].expRd});
            checkOutput($sformatf("vec%0d status", i), {56'd0, status}, {56'd0, vecs[i].expStatus});
        end

        // FMA: operands stable over the whole busy window, result 5.0, one entry left.
        exValue = 64'h0000_0000_40A0_0000;
        pushWord(32'h3F80_0000);
        pushWord(32'h4000_0000);
        pushWord(32'h4040_0000);
        sendCmd(8'h07);
        for (int k = 0; k < LATENCY; k++) begin
            checkOutput($sformatf("fma busy%0d", k), {63'd0, status[7]}, 64'd1);
            checkOutput($sformatf("fma func%0d", k), {56'd0, exFunc}, {56'd0, FUNC_FMA});
            checkOutput($sformatf("fma fmt%0d", k), {56'd0, exFmt}, {56'd0, FMT_B32});
            checkOutput($sformatf("fma op0_%0d", k), exOp0, 64'h3F80_0000);
            checkOutput($sformatf("fma op1_%0d", k), exOp1, 64'h4000_0000);
            checkOutput($sformatf("fma op2_%0d", k), exOp2, 64'h4040_0000);
            idleCycles(1);
        end
        checkOutput("fma done busy", {63'd0, status[7]}, 64'd0);
        checkOutput("fma idle func", {56'd0, exFunc}, 64'd0);
        checkOutput("fma idle fmt", {56'd0, exFmt}, 64'd0);
        checkOutput("fma idle op0", exOp0, 64'd0);
        checkOutput("fma idle op2", exOp2, 64'd0);
        readWord("fma result", 32'h40A0_0000);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("fma count1 empty", {56'd0, status}, 64'h10);
        sendCmd(8'h00);

        // ADD operand routing: op0 = NOS, op1 = TOS.
        exValue = 64'h0000_0000_4040_0000;
        pushWord(32'h3F80_0000);
        pushWord(32'h4000_0000);
        sendCmd(8'h01);
        checkOutput("add func", {56'd0, exFunc}, {56'd0, FUNC_ADD});
        checkOutput("add op0", exOp0, 64'h3F80_0000);
        checkOutput("add op1", exOp1, 64'h4000_0000);
        checkOutput("add op2", exOp2, 64'd0);
        idleCycles(LATENCY);
        readWord("add result", 32'h4040_0000);

        // Overflow: ninth push dropped, eighth word stays on top.
        for (int k = 1; k <= 9; k++) pushWord(32'h3F80_0000 + 32'(k));
        checkOutput("ovf status", {56'd0, status}, 64'h08);
        readWord("ovf tos", 32'h3F80_0008);
        // SQRT with a stray host write attempted while busy.
        exValue = 64'hFFFF_FFFF_1234_5678;
        sendCmd(8'h05);
        checkOutput("exec ready low", {63'd0, hostReady}, 64'd0);
        checkOutput("sqrt op0", exOp0, 64'h3F80_0007);
        applyStimulus(1'b1, 1'b0, 8'hEE, 1'b0);
        idleCycles(LATENCY - 1);
        checkOutput("sqrt done busy", {63'd0, status[7]}, 64'd0);
        readWord("sqrt result", 32'h1234_5678);
        pushWord(32'hAABB_CCDD);
        readWord("after stray", 32'hAABB_CCDD);
        checkOutput("ovf sticky", {56'd0, status}, 64'h08);

        // DIV reporting failure: err_inv set, stack untouched.
        rst = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        exStatus = 16'h0001;
        pushWord(32'h4000_0000);
        pushWord(32'hC080_0000);
        sendCmd(8'h04);
        idleCycles(LATENCY);
        checkOutput("div fail status", {56'd0, status}, 64'h44);
        readWord("div tos", 32'hC080_0000);
        readWord("div nos", 32'h4000_0000);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("div count", {56'd0, status}, 64'h14);
        exStatus = 16'h0000;
        sendCmd(8'h00);
        sendCmd(8'h0F);
        checkOutput("bad cmd status", {56'd0, status}, 64'h04);
        checkOutput("bad cmd ready", {63'd0, hostReady}, 64'd1);
        sendCmd(8'h00);

        // Reset in the second EXEC cycle aborts without writeback.
        pushWord(32'h3F80_0000);
        pushWord(32'h4000_0000);
        sendCmd(8'h01);
        idleCycles(1);
        checkOutput("pre-reset busy", {56'd0, status}, 64'h80);
        rst = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        checkOutput("abort status", {56'd0, status}, 64'd0);
        checkOutput("abort ready", {63'd0, hostReady}, 64'd1);
        checkOutput("abort func", {56'd0, exFunc}, 64'd0);
        checkOutput("abort fmt", {56'd0, exFmt}, 64'd0);
        checkOutput("abort op0", exOp0, 64'd0);
        checkOutput("abort op1", exOp1, 64'd0);
        idleCycles(LATENCY);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("abort count", {56'd0, status}, 64'h10);
        checkOutput("abort rd_data", {56'd0, rdData}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
